wb_gpio_irq: RTL

WB_GPIO_IRQ -- requirements
Module: wb_gpio_irq

---
 rtl/wb_gpio_irq_pkg.sv | 33 +++
 rtl/gpio_edge_sync.sv | 42 ++++
 rtl/wb_gpio_irq.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/wb_gpio_irq_pkg.sv
// rtl/wb_gpio_irq_pkg.sv - shared constants, bus FSM states and byte-lane helper for wb_gpio_irq
package wb_gpio_irq_pkg;

  localparam int MAX_NIO = 64;

  localparam logic [7:0] OFF_OUT_LO  = 8'h00;
  localparam logic [7:0] OFF_OUT_HI  = 8'h04;
  localparam logic [7:0] OFF_OEB_LO  = 8'h08;
  localparam logic [7:0] OFF_OEB_HI  = 8'h0C;
  localparam logic [7:0] OFF_IN_LO   = 8'h10;
  localparam logic [7:0] OFF_IN_HI   = 8'h14;
  localparam logic [7:0] OFF_IEN_LO  = 8'h18;
  localparam logic [7:0] OFF_IEN_HI  = 8'h1C;
  localparam logic [7:0] OFF_IST_LO  = 8'h20;
  localparam logic [7:0] OFF_IST_HI  = 8'h24;
  localparam logic [7:0] OFF_EDGE_LO = 8'h28;
  localparam logic [7:0] OFF_EDGE_HI = 8'h2C;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} bus_state_e;

  // Replace the bytes of old_w selected by sel with the matching bytes of new_w.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/gpio_edge_sync.sv
// rtl/gpio_edge_sync.sv - per-pin two-flop synchroniser with rising/falling edge detection
module gpio_edge_sync
  import wb_gpio_irq_pkg::*;
#(
  parameter int WIDTH = 38
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] dly_q;
  logic [1:0]       arm_q;
  logic             armed;

  // Synchroniser chain plus one delayed copy; arm_q hides the edge a high pad
  // would otherwise show while the chain fills after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      dly_q  <= '0;
      arm_q  <= 2'd0;
    end else begin
      meta_q <= pin_in;
      sync_q <= meta_q;
      dly_q  <= sync_q;
      if (arm_q != 2'd3) arm_q <= arm_q + 2'd1;
    end
  end

  assign armed    = (arm_q == 2'd3);
  assign pin_sync = sync_q;
  assign rise     = {WIDTH{armed}} & sync_q & ~dly_q;
  assign fall     = {WIDTH{armed}} & ~sync_q & dly_q;

endmodule

// File: rtl/wb_gpio_irq.sv
// rtl/wb_gpio_irq.sv - Wishbone slave GPIO block with edge-triggered interrupts
module wb_gpio_irq
  import wb_gpio_irq_pkg::*;
#(
  parameter int          NIO         = 38,
  parameter int          NIRQ        = 3,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADR    = 32'h3000_0000
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  input  logic [3:0]      wbs_sel_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [NIO-1:0]  io_in,
  output logic [NIO-1:0]  io_out,
  output logic [NIO-1:0]  io_oeb,
  output logic [NIRQ-1:0] user_irq
);

  localparam logic [63:0] PIN_MASK = (NIO >= MAX_NIO) ? {64{1'b1}} : ((64'd1 << NIO) - 64'd1);
  localparam logic [2:0]  WS_LAST  = 3'(WAIT_STATES - 1);

  bus_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       req, hit, ack_cycle, wr_en;
  logic [7:0] off;

  logic [63:0] out_q, oeb_q, ien_q, ist_q, edge_q, ist_d, w1c;
  logic [63:0] in_pad, rise_pad, fall_pad;
  logic [NIO-1:0] pin_sync, pin_rise, pin_fall;
  logic [31:0] rd_word;
  logic [NIRQ-1:0] irq_d;

  assign req       = wbs_cyc_i & wbs_stb_i;
  assign hit       = req & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign off       = wbs_adr_i[7:0];
  assign ack_cycle = (state_q == ST_ACK);
  assign wr_en     = ack_cycle & req & wbs_we_i;

  gpio_edge_sync #(.WIDTH(NIO)) u_edge_sync (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_ni),
    .pin_in   (io_in),
    .pin_sync (pin_sync),
    .rise     (pin_rise),
    .fall     (pin_fall)
  );

  // Widen per-pin vectors to the full 64-bit register space.
  always_comb begin
    in_pad   = '0;
    rise_pad = '0;
    fall_pad = '0;
    in_pad[NIO-1:0]   = pin_sync;
    rise_pad[NIO-1:0] = pin_rise;
    fall_pad[NIO-1:0] = pin_fall;
  end

  // Bus FSM state and wait counter.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: wait WAIT_STATES cycles, abort if the master withdraws, one-cycle ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 3'd0;
        if (hit) state_d = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
      end
      ST_WAIT: begin
        if (!req)                  state_d = ST_IDLE;
        else if (cnt_q == WS_LAST) state_d = ST_ACK;
        else                       cnt_d   = cnt_q + 3'd1;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Interrupt status: new edges of the selected polarity win over a same-cycle clear.
  always_comb begin
    w1c = '0;
    if (wr_en && off == OFF_IST_LO) w1c[31:0]  = lane_merge(32'h0, wbs_dat_i, wbs_sel_i);
    if (wr_en && off == OFF_IST_HI) w1c[63:32] = lane_merge(32'h0, wbs_dat_i, wbs_sel_i);
    ist_d = ((ist_q & ~w1c) | (edge_q & fall_pad) | (~edge_q & rise_pad)) & PIN_MASK;
  end

  // Register file; writes land at the end of the ack cycle, bits above NIO stay 0.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      out_q  <= '0;
      oeb_q  <= PIN_MASK;
      ien_q  <= '0;
      ist_q  <= '0;
      edge_q <= '0;
    end else begin
      ist_q <= ist_d;
      if (wr_en) begin
        case (off)
          OFF_OUT_LO:  out_q[31:0]   <= lane_merge(out_q[31:0],   wbs_dat_i, wbs_sel_i) & PIN_MASK[31:0];
          OFF_OUT_HI:  out_q[63:32]  <= lane_merge(out_q[63:32],  wbs_dat_i, wbs_sel_i) & PIN_MASK[63:32];
          OFF_OEB_LO:  oeb_q[31:0]   <= lane_merge(oeb_q[31:0],   wbs_dat_i, wbs_sel_i) & PIN_MASK[31:0];
          OFF_OEB_HI:  oeb_q[63:32]  <= lane_merge(oeb_q[63:32],  wbs_dat_i, wbs_sel_i) & PIN_MASK[63:32];
          OFF_IEN_LO:  ien_q[31:0]   <= lane_merge(ien_q[31:0],   wbs_dat_i, wbs_sel_i) & PIN_MASK[31:0];
          OFF_IEN_HI:  ien_q[63:32]  <= lane_merge(ien_q[63:32],  wbs_dat_i, wbs_sel_i) & PIN_MASK[63:32];
          OFF_EDGE_LO: edge_q[31:0]  <= lane_merge(edge_q[31:0],  wbs_dat_i, wbs_sel_i) & PIN_MASK[31:0];
          OFF_EDGE_HI: edge_q[63:32] <= lane_merge(edge_q[63:32], wbs_dat_i, wbs_sel_i) & PIN_MASK[63:32];
          default: ;
        endcase
      end
    end
  end

  // Read mux; unmapped offsets read 0.
  always_comb begin
    rd_word = '0;
    case (off)
      OFF_OUT_LO:  rd_word = out_q[31:0];
      OFF_OUT_HI:  rd_word = out_q[63:32];
      OFF_OEB_LO:  rd_word = oeb_q[31:0];
      OFF_OEB_HI:  rd_word = oeb_q[63:32];
      OFF_IN_LO:   rd_word = in_pad[31:0];
      OFF_IN_HI:   rd_word = in_pad[63:32];
      OFF_IEN_LO:  rd_word = ien_q[31:0];
      OFF_IEN_HI:  rd_word = ien_q[63:32];
      OFF_IST_LO:  rd_word = ist_q[31:0];
      OFF_IST_HI:  rd_word = ist_q[63:32];
      OFF_EDGE_LO: rd_word = edge_q[31:0];
      OFF_EDGE_HI: rd_word = edge_q[63:32];
      default:     rd_word = '0;
    endcase
  end

  // Pins are spread round-robin over the interrupt lines.
  always_comb begin
    irq_d = '0;
    for (int k = 0; k < NIRQ; k++) begin
      for (int i = 0; i < MAX_NIO; i++) begin
        if ((i % NIRQ) == k) irq_d[k] = irq_d[k] | (ist_q[i] & ien_q[i]);
      end
    end
  end

  // Registered interrupt outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) user_irq <= '0;
    else            user_irq <= irq_d;
  end

  assign wbs_ack_o = ack_cycle;
  assign wbs_dat_o = (ack_cycle && !wbs_we_i) ? rd_word : 32'h0;
  assign io_out    = out_q[NIO-1:0];
  assign io_oeb    = oeb_q[NIO-1:0];

endmodule
